// File: rtl/led_sw_mode_ctrl_if.sv
// Pin-side bundle for the LED/switch controller: raw switches and mode in,
// LED drive, debounced switches and timebase tick out.
interface led_sw_mode_ctrl_if #(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned SW_NUM  = 3
);
  logic [SW_NUM-1:0]  sw;
  logic [1:0]         mode;
  logic [LED_NUM-1:0] led;
  logic [SW_NUM-1:0]  sw_db;
  logic               tick;

  modport master (
    output sw,
    output mode,
    input  led,
    input  sw_db,
    input  tick
  );

  modport slave (
    input  sw,
    input  mode,
    output led,
    output sw_db,
    output tick
  );
endinterface

// File: rtl/led_sw_mode_ctrl.sv
// LED/switch controller: synchronised and debounced switches drive the LEDs
// in direct, toggle, blink or chase mode; exports sw_db and the timebase tick.
module led_sw_mode_ctrl #(
  parameter int unsigned LED_NUM         = 4,
  parameter int unsigned SW_NUM          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  led_sw_mode_ctrl_if.slave bus
);

  localparam int unsigned K  = (LED_NUM < SW_NUM) ? LED_NUM : SW_NUM;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  logic [SW_NUM-1:0]          s1_q, s1_d, s2_q, s2_d;
  logic [1:0]                 m1_q, m1_d, m2_q, m2_d;
  mode_e                      mode_q, mode_d;
  logic [SW_NUM-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [SW_NUM-1:0]          sw_db_q, sw_db_d;
  logic [K-1:0]               db_dly_q, db_dly_d;
  logic [K-1:0]               tgl_q, tgl_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic                       tick_q, tick_d;
  logic                       phase_q, phase_d;
  logic [LED_NUM-1:0]         pos_q, pos_d;
  logic [LED_NUM-1:0]         led_q, led_d;

  logic                       mode_chg;
  logic                       tick_evt;
  logic [K-1:0]               rise;

  function automatic logic [LED_NUM-1:0] rotl(input logic [LED_NUM-1:0] v);
    return (v << 1) | (v >> (LED_NUM - 1));
  endfunction

  function automatic logic [LED_NUM-1:0] rotr(input logic [LED_NUM-1:0] v);
    return (v >> 1) | (v << (LED_NUM - 1));
  endfunction

  always_comb begin
    s1_d = bus.sw;
    s2_d = s1_q;
    m1_d = bus.mode;
    m2_d = m1_q;
    mode_d = mode_e'(m2_q);
    mode_chg = (m2_q != mode_q);
  end

  // A count only survives while the synchronised input keeps disagreeing.
  always_comb begin
    cnt_d   = '0;
    sw_db_d = sw_db_q;
    for (int unsigned i = 0; i < SW_NUM; i++) begin
      if (s2_q[i] != sw_db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // A mode change restarts the timebase and suppresses any coincident tick.
  always_comb begin
    tick_evt = (tcnt_q == TCNT_LAST) && !mode_chg;
    if (mode_chg || (tcnt_q == TCNT_LAST)) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
    tick_d  = tick_evt;
    phase_d = mode_chg ? 1'b1 : (phase_q ^ tick_evt);
  end

  always_comb begin
    db_dly_d = sw_db_q[K-1:0];
    rise     = sw_db_q[K-1:0] & ~db_dly_q;
    tgl_d    = tgl_q;
    if (mode_chg) begin
      tgl_d = '0;
    end else if (mode_q == MODE_TOGGLE) begin
      tgl_d = tgl_q ^ rise;
    end
  end

  always_comb begin
    pos_d = pos_q;
    if (mode_chg) begin
      pos_d = LED_NUM'(1);
    end else if (tick_evt && (mode_q == MODE_CHASE) && !sw_db_q[1]) begin
      pos_d = sw_db_q[0] ? rotr(pos_q) : rotl(pos_q);
    end
  end

  always_comb begin
    led_d = '0;
    if (!mode_chg) begin
      case (mode_q)
        MODE_DIRECT: led_d[K-1:0] = sw_db_q[K-1:0];
        MODE_TOGGLE: led_d[K-1:0] = tgl_q;
        MODE_BLINK:  led_d[K-1:0] = sw_db_q[K-1:0] & {K{phase_q}};
        MODE_CHASE:  led_d        = pos_q;
        default:     led_d        = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      mode_q   <= MODE_DIRECT;
      cnt_q    <= '0;
      sw_db_q  <= '0;
      db_dly_q <= '0;
      tgl_q    <= '0;
      tcnt_q   <= '0;
      tick_q   <= 1'b0;
      phase_q  <= 1'b1;
      pos_q    <= LED_NUM'(1);
      led_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      sw_db_q  <= sw_db_d;
      db_dly_q <= db_dly_d;
      tgl_q    <= tgl_d;
      tcnt_q   <= tcnt_d;
      tick_q   <= tick_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      led_q    <= led_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.sw_db = sw_db_q;
  assign bus.tick  = tick_q;

endmodule
